stream_accumulator: RTL and testbench

Multi-cycle accumulator that sits directly downstream of the team's n-bit ripple adder stage. It consumes a stream of N-bit operands over a valid/ready handshake and feeds each operand plus the running total through an N-bit add with carry-out. After a programmed number of operands it presents the final sum and a sticky overflow flag on an output valid/ready handshake. It turns the combinational adder into a sequenced reduction unit that a controller or downstream datapath can consume.

---
 rtl/stream_accumulator.sv | 92 +++++++++
 tb/tb_stream_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_accumulator.sv
// Sequenced reduction unit: accumulates a programmed number of N-bit operands
// through an (N+1)-bit add and presents the sum with a sticky carry-out flag.
module stream_accumulator #(
   parameter int N  = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_sum,
   output logic          out_carry,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [N-1:0]  acc;
   logic          carry;
   logic [CW-1:0] remaining;
   logic          start_ok;
   logic          accept;
   logic [N:0]    sum_ext;

   // Carry is bit N of the widened add, never inferred from wrap-around.
   assign sum_ext = {1'b0, acc} + {1'b0, in_data};

   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      start_ok  = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_ok  = 1'b1;
               state_nxt = (len == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (remaining == CW'(1)) state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign out_sum   = acc;
   assign out_carry = carry;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         carry     <= 1'b0;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         if (start_ok) begin
            acc       <= '0;
            carry     <= 1'b0;
            remaining <= len;
         end else if (accept) begin
            acc       <= sum_ext[N-1:0];
            carry     <= carry | sum_ext[N];
            remaining <= remaining - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_stream_accumulator.sv
// Self-checking bench for stream_accumulator: directed scenarios plus randomized
// runs compared against an arithmetic reference (true total of the operands).
module tb_stream_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_sum;
   logic        out_carry;
   logic        busy;

   int total = 0;
   int bad   = 0;

   stream_accumulator #(.N(16), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int l);
      start = 1'b1;
      len   = 8'(l);
      tick();
      start = 1'b0;
      len   = 8'($urandom);
   endtask

   // Offer one operand for one cycle; reports whether it was accepted.
   task automatic feed(input logic [15:0] op, output bit taken);
      in_valid = 1'b1;
      in_data  = op;
      taken    = in_ready;
      tick();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({in_ready, out_valid, out_sum, out_carry, busy} !== 20'd0) begin
         bad++;
         $display("FAIL reset_outputs: got rdy=%b ov=%b sum=%h c=%b busy=%b, want all 0",
                  in_ready, out_valid, out_sum, out_carry, busy);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      bit t;
      do_start(3);
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         bad++; $display("FAIL basic_start: busy=%b in_ready=%b, want 1 1", busy, in_ready);
      end
      feed(16'h0001, t);
      feed(16'h0002, t);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
      feed(16'h0003, t);
      total++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0006 || out_carry !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_result: ov=%b sum=%h c=%b rdy=%b, want 1 0006 0 0",
                  out_valid, out_sum, out_carry, in_ready);
      end
      handshake();
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL basic_return_idle: busy=%b ov=%b, want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_overflow();
      bit t;
      do_start(2);
      feed(16'hFFFF, t);
      feed(16'h0002, t);
      total++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0001 || out_carry !== 1'b1) begin
         bad++; $display("FAIL overflow_result: ov=%b sum=%h c=%b, want 1 0001 1", out_valid, out_sum, out_carry);
      end
      handshake();
      do_start(1);
      feed(16'h0005, t);
      total++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0005 || out_carry !== 1'b0) begin
         bad++; $display("FAIL overflow_sticky_clear: ov=%b sum=%h c=%b, want 1 0005 0", out_valid, out_sum, out_carry);
      end
      handshake();
   endtask

   task automatic test_backpressure();
      bit          pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [15:0] ops [4];
      longint      ref_total = 0;
      int          idx = 0;
      for (int i = 0; i < 4; i++) begin
         ops[i] = 16'($urandom);
         ref_total += ops[i];
      end
      do_start(4);
      for (int i = 0; i < 7; i++) begin
         in_valid = pattern[i];
         in_data  = pattern[i] ? ops[idx] : 16'($urandom);
         if (pattern[i]) idx++;
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'(ref_total)
             || out_carry !== (ref_total >= 65536)) begin
            bad++;
            $display("FAIL backpressure_hold[%0d]: ov=%b rdy=%b sum=%h c=%b, want 1 0 %h %b",
                     i, out_valid, in_ready, out_sum, out_carry, 16'(ref_total), ref_total >= 65536);
         end
         tick();
      end
      in_valid = 1'b0;
      handshake();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL backpressure_release: busy=%b want 0", busy); end
   endtask

   task automatic test_zero_len();
      do_start(0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         total++;
         if (out_valid !== 1'b1 || out_sum !== 16'h0000 || out_carry !== 1'b0
             || in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_len[%0d]: ov=%b sum=%h c=%b rdy=%b busy=%b, want 1 0000 0 0 1",
                     i, out_valid, out_sum, out_carry, in_ready, busy);
         end
         tick();
      end
      in_valid = 1'b0;
      handshake();
   endtask

   task automatic test_reset_mid();
      bit t;
      do_start(4);
      feed(16'h1234, t);
      feed(16'h4321, t);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if ({in_ready, out_valid, out_sum, out_carry, busy} !== 20'd0) begin
         bad++;
         $display("FAIL reset_mid_outputs: rdy=%b ov=%b sum=%h c=%b busy=%b, want all 0",
                  in_ready, out_valid, out_sum, out_carry, busy);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_mid_no_result: ov=%b busy=%b, want 0 0", out_valid, busy);
      end
      do_start(1);
      feed(16'h0007, t);
      total++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0007 || out_carry !== 1'b0) begin
         bad++; $display("FAIL reset_mid_rerun: ov=%b sum=%h c=%b, want 1 0007 0", out_valid, out_sum, out_carry);
      end
      handshake();
   endtask

   task automatic test_full_length();
      int accepts = 0;
      int cyc = 0;
      do_start(255);
      while (out_valid !== 1'b1 && cyc < 600) begin
         in_valid = 1'b1;
         in_data  = 16'h0101;
         start    = cyc[0];
         len      = 8'd3;
         if (in_ready === 1'b1) accepts++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      total++;
      if (out_valid !== 1'b1 || accepts != 255 || out_sum !== 16'hFFFF || out_carry !== 1'b0) begin
         bad++;
         $display("FAIL full_length: ov=%b accepts=%0d sum=%h c=%b, want 1 255 ffff 0",
                  out_valid, accepts, out_sum, out_carry);
      end
      start     = 1'b1;
      len       = 8'd5;
      out_ready = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL handshake_start_ignored: busy=%b ov=%b, want 0 0", busy, out_valid);
      end
      tick();
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_stays_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         int          l = $urandom_range(1, 20);
         logic [15:0] ops [$];
         longint      ref_total = 0;
         int          idx = 0;
         int          cyc = 0;
         for (int i = 0; i < l; i++) begin
            ops.push_back(16'($urandom_range(0, 3) == 0 ? 16'hFFFF - 16'($urandom_range(0, 15)) : 16'($urandom)));
            ref_total += ops[i];
         end
         do_start(l);
         while (idx < l && cyc < 200) begin
            bit v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? ops[idx] : 16'($urandom);
            if (v && in_ready === 1'b1) idx++;
            tick();
            cyc++;
         end
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'b1 || out_sum !== 16'(ref_total) || out_carry !== (ref_total >= 65536)) begin
            bad++;
            $display("FAIL random_run[%0d] len=%0d: ov=%b sum=%h c=%b, want 1 %h %b",
                     r, l, out_valid, out_sum, out_carry, 16'(ref_total), ref_total >= 65536);
         end
         repeat ($urandom_range(0, 3)) tick();
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
      test_full_length();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
